// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature-sensor target:
// FSM state encoding, bus-level constants and the default target address.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6
    } i2c_state_t;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic       I2C_RD           = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h4B;

    // Byte 0 of a read is the high half of the sample, byte 1 the low half.
    function automatic logic [7:0] rd_byte_sel(input logic [15:0] sample, input logic idx);
        return idx ? sample[7:0] : sample[15:8];
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one open-drain bus line plus a history flop that turns
// the synchronized level into single-cycle rise/fall strobes.
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    // Shift the raw line into the chain; history holds the previous synchronized level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], line_in};
        hist_d = sync_q[STAGES-1];
    end

    // Reset to the idle-bus level (high) so reset release never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target emulating a temperature sensor: accepts pointer writes and
// returns a 16-bit sample (MSB first) on reads. The bus is oversampled on clk;
// SDA is only ever pulled low, and only changes after an SCL falling edge.
module i2c_temp_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_pull,
    input  logic [15:0] temp_data,
    output logic [7:0]  ptr,
    output logic        ptr_valid,
    output logic        rd_done,
    output logic        busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_state_t  state_q,     state_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic        rw_q,        rw_d;
    logic        byte_idx_q,  byte_idx_d;
    logic [15:0] temp_q,      temp_d;
    logic        sda_pull_q,  sda_pull_d;
    logic [7:0]  ptr_q,       ptr_d;
    logic        ptr_valid_q, ptr_valid_d;
    logic        rd_done_q,   rd_done_d;
    logic        busy_q,      busy_d;

    logic [7:0]  cur_byte;
    logic [2:0]  bit_sel;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    // START/STOP are SDA edges while SCL is high; they take priority over any data edge.
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    // bit_cnt counts bits already driven in RD_BYTE, so it selects the next bit to drive.
    assign cur_byte = rd_byte_sel(temp_q, byte_idx_q);
    assign bit_sel  = 3'd7 - bit_cnt_q[2:0];

    // Next-state logic: bits are sampled on SCL rise, SDA is updated on SCL fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        byte_idx_d  = byte_idx_q;
        temp_d      = temp_q;
        sda_pull_d  = sda_pull_q;
        ptr_d       = ptr_q;
        ptr_valid_d = 1'b0;
        rd_done_d   = 1'b0;
        busy_d      = busy_q;

        if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 4'd0;
            busy_d     = 1'b1;
            sda_pull_d = 1'b0;
        end else if (stop_det) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 4'd0;
            busy_d     = 1'b0;
            sda_pull_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            // shift_q[6:0] holds the 7 address bits; the current bit is R/W.
                            if (shift_q[6:0] == ADDR) begin
                                rw_d    = sda_lvl;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_pull_d = 1'b1;
                            bit_cnt_d  = 4'd1;
                        end else if (rw_q == I2C_RD) begin
                            // Capture the sample once and drive its MSB on this same fall.
                            temp_d     = temp_data;
                            byte_idx_d = 1'b0;
                            sda_pull_d = ~temp_data[15];
                            bit_cnt_d  = 4'd1;
                            state_d    = ST_RD_BYTE;
                        end else begin
                            sda_pull_d = 1'b0;
                            bit_cnt_d  = 4'd0;
                            state_d    = ST_WR_BYTE;
                        end
                    end
                end

                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            state_d   = ST_WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_pull_d  = 1'b1;
                            bit_cnt_d   = 4'd1;
                            ptr_d       = shift_q;
                            ptr_valid_d = 1'b1;
                        end else begin
                            sda_pull_d = 1'b0;
                            bit_cnt_d  = 4'd0;
                            state_d    = ST_WR_BYTE;
                        end
                    end
                end

                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_pull_d = 1'b0;
                            bit_cnt_d  = 4'd0;
                            state_d    = ST_RD_ACK;
                        end else begin
                            sda_pull_d = ~cur_byte[bit_sel];
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (byte_idx_q) begin
                            rd_done_d = 1'b1;
                        end
                        if (sda_lvl == I2C_ACK) begin
                            // After byte 1 this wraps back to byte 0 of the same sample.
                            byte_idx_d = ~byte_idx_q;
                            bit_cnt_d  = 4'd0;
                            state_d    = ST_RD_BYTE;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    sda_pull_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            byte_idx_q  <= 1'b0;
            temp_q      <= 16'h0000;
            sda_pull_q  <= 1'b0;
            ptr_q       <= 8'h00;
            ptr_valid_q <= 1'b0;
            rd_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            byte_idx_q  <= byte_idx_d;
            temp_q      <= temp_d;
            sda_pull_q  <= sda_pull_d;
            ptr_q       <= ptr_d;
            ptr_valid_q <= ptr_valid_d;
            rd_done_q   <= rd_done_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_pull  = sda_pull_q;
    assign ptr       = ptr_q;
    assign ptr_valid = ptr_valid_q;
    assign rd_done   = rd_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_temp_target.sv
// Self-checking bench: a bit-banged I2C master drives the target through a
// table of whole transactions, then hand-written repeated-START, sample-hold,
// wrap-around and mid-read reset sequences.
module tb_i2c_temp_target;

    localparam int H = 16;  // clk cycles per SCL half period

    logic        clk = 1'b0;
    logic        reset;
    logic        scl;
    logic        m_sda;      // master side: 1 = released, 0 = pulled low
    logic        sda_bus;
    logic        sda_pull;
    logic [15:0] temp_data;
    logic [7:0]  ptr;
    logic        ptr_valid;
    logic        rd_done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int pv_cnt     = 0;
    int rd_cnt     = 0;
    int pull_cnt   = 0;
    int glitch_cnt = 0;
    logic prev_pull = 1'b0;
    logic mon_en    = 1'b0;

    typedef struct {
        string       name;
        logic [7:0]  addr_b;
        logic [7:0]  wr_b;
        logic [15:0] temp;
        logic        exp_ack;
        logic [15:0] exp_rd;
        logic [7:0]  exp_ptr;
        int          exp_pv;
        int          exp_rdd;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_pull;

    i2c_temp_target dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_bus),
        .sda_pull  (sda_pull),
        .temp_data (temp_data),
        .ptr       (ptr),
        .ptr_valid (ptr_valid),
        .rd_done   (rd_done),
        .busy      (busy)
    );

    // Pulse counters and a monitor for SDA changes while SCL is high.
    always @(posedge clk) begin
        prev_pull <= sda_pull;
        if (ptr_valid) pv_cnt <= pv_cnt + 1;
        if (rd_done) rd_cnt <= rd_cnt + 1;
        if (sda_pull) pull_cnt <= pull_cnt + 1;
        if (mon_en && scl && (sda_pull !== prev_pull)) glitch_cnt <= glitch_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(H/2);
        scl = 1'b1;   wait_clk(H);
        m_sda = 1'b0; wait_clk(H);
        scl = 1'b0;   wait_clk(H/2);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(H/2);
        scl = 1'b1;   wait_clk(H);
        m_sda = 1'b1; wait_clk(H);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        m_sda = b;  wait_clk(H/2);
        scl = 1'b1; wait_clk(H/2);
        s = sda_bus; wait_clk(H/2);
        scl = 1'b0; wait_clk(H/2);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(mack, s);
    endtask

    function automatic vec_t mkvec(input string name, input logic [7:0] addr_b,
                                   input logic [7:0] wr_b, input logic [15:0] temp,
                                   input logic exp_ack, input logic [15:0] exp_rd,
                                   input logic [7:0] exp_ptr, input int exp_pv,
                                   input int exp_rdd);
        vec_t v;
        v.name = name; v.addr_b = addr_b; v.wr_b = wr_b; v.temp = temp;
        v.exp_ack = exp_ack; v.exp_rd = exp_rd; v.exp_ptr = exp_ptr;
        v.exp_pv = exp_pv; v.exp_rdd = exp_rdd;
        return v;
    endfunction

    // One complete transaction: address, then a 2-byte read or a 1-byte write, then STOP.
    task automatic run_vec(input vec_t v);
        int pv0, rd0, pl0;
        logic ack;
        logic [7:0] b0, b1;
        pv0 = pv_cnt; rd0 = rd_cnt; pl0 = pull_cnt;
        temp_data = v.temp;
        i2c_start();
        write_byte(v.addr_b, ack);
        chk({v.name, "_addr_ack"}, 32'(ack), 32'(v.exp_ack));
        if (v.exp_ack == 1'b0) begin
            chk({v.name, "_busy_mid"}, 32'(busy), 32'd1);
            if (v.addr_b[0]) begin
                read_byte(1'b0, b0);
                read_byte(1'b1, b1);
                chk({v.name, "_rdata"}, 32'({b0, b1}), 32'(v.exp_rd));
            end else begin
                write_byte(v.wr_b, ack);
                chk({v.name, "_data_ack"}, 32'(ack), 32'd0);
            end
        end else begin
            chk({v.name, "_idle_busy"}, 32'(busy), 32'd0);
            chk({v.name, "_no_pull"}, 32'(pull_cnt - pl0), 32'd0);
        end
        i2c_stop();
        chk({v.name, "_busy_end"}, 32'(busy), 32'd0);
        chk({v.name, "_ptr"}, 32'(ptr), 32'(v.exp_ptr));
        chk({v.name, "_ptr_valid_cnt"}, 32'(pv_cnt - pv0), 32'(v.exp_pv));
        chk({v.name, "_rd_done_cnt"}, 32'(rd_cnt - rd0), 32'(v.exp_rdd));
    endtask

    initial begin
        logic ack, s;
        logic [7:0] b0, b1, b2;
        int pv0, rd0, pl0;

        vecs[0] = mkvec("rd_1A2C",   8'h97, 8'h00, 16'h1A2C, 1'b0, 16'h1A2C, 8'h00, 0, 1);
        vecs[1] = mkvec("wr_03",     8'h96, 8'h03, 16'h0000, 1'b0, 16'h0000, 8'h03, 1, 0);
        vecs[2] = mkvec("bad_91",    8'h91, 8'h00, 16'h0000, 1'b1, 16'h0000, 8'h03, 0, 0);
        vecs[3] = mkvec("wr_A5",     8'h96, 8'hA5, 16'h0000, 1'b0, 16'h0000, 8'hA5, 1, 0);
        vecs[4] = mkvec("rd_8001",   8'h97, 8'h00, 16'h8001, 1'b0, 16'h8001, 8'hA5, 0, 1);
        vecs[5] = mkvec("bad_94_wr", 8'h94, 8'h00, 16'h0000, 1'b1, 16'h0000, 8'hA5, 0, 0);

        reset = 1'b1; scl = 1'b1; m_sda = 1'b1; temp_data = 16'h0000;
        wait_clk(5);
        chk("rst_sda_pull", 32'(sda_pull), 32'd0);
        chk("rst_ptr", 32'(ptr), 32'h00);
        chk("rst_ptr_valid", 32'(ptr_valid), 32'd0);
        chk("rst_rd_done", 32'(rd_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_clk(H);
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Repeated START: pointer write, then read without an intervening STOP.
        pv0 = pv_cnt; rd0 = rd_cnt;
        temp_data = 16'hFF00;
        i2c_start();
        write_byte(8'h96, ack); chk("rs_addr_w_ack", 32'(ack), 32'd0);
        write_byte(8'h00, ack); chk("rs_ptr_ack", 32'(ack), 32'd0);
        i2c_start();
        write_byte(8'h97, ack); chk("rs_addr_r_ack", 32'(ack), 32'd0);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        i2c_stop();
        chk("rs_rdata", 32'({b0, b1}), 32'hFF00);
        chk("rs_ptr", 32'(ptr), 32'h00);
        chk("rs_ptr_valid_cnt", 32'(pv_cnt - pv0), 32'd1);
        chk("rs_rd_done_cnt", 32'(rd_cnt - rd0), 32'd1);

        // Sample is held once captured at the address ACK.
        temp_data = 16'h1234;
        i2c_start();
        write_byte(8'h97, ack); chk("hold_addr_ack", 32'(ack), 32'd0);
        temp_data = 16'hABCD;
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        i2c_stop();
        chk("hold_rdata", 32'({b0, b1}), 32'h1234);

        // ACK after byte 1 wraps to byte 0 of the same sample; rd_done only after byte 1.
        rd0 = rd_cnt;
        temp_data = 16'hC35A;
        i2c_start();
        write_byte(8'h97, ack); chk("wrap_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, b0);
        read_byte(1'b0, b1);
        read_byte(1'b1, b2);
        i2c_stop();
        chk("wrap_rdata", 32'({b0, b1, b2}), 32'hC35AC3);
        chk("wrap_rd_done_cnt", 32'(rd_cnt - rd0), 32'd1);
        chk("wrap_busy_end", 32'(busy), 32'd0);

        // Reset during byte 0 of a read while the target is pulling SDA low.
        temp_data = 16'h00FF;
        i2c_start();
        write_byte(8'h97, ack); chk("rst_rd_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
        chk("rst_rd_driving", 32'(sda_pull), 32'd1);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rd_pull_released", 32'(sda_pull), 32'd0);
        chk("rst_rd_busy", 32'(busy), 32'd0);
        pl0 = pull_cnt;
        for (int i = 0; i < 5; i++) bit_cycle(1'b1, s);
        i2c_stop();
        chk("rst_rd_silent", 32'(pull_cnt - pl0), 32'd0);
        mon_en = 1'b1;
        run_vec(mkvec("post_rst_rd_0F0F", 8'h97, 8'h00, 16'h0F0F, 1'b0, 16'h0F0F, 8'h00, 0, 1));

        chk("no_sda_change_scl_high", 32'(glitch_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_temp_target.md
# i2c_temp_target

I2C target (responder) that plays the temperature-sensor end of the bus driven by the team's I2C master. It receives START/address/pointer writes and answers reads with a 16-bit sample, MSB first. It runs on the system clock and oversamples SCL/SDA. It serves as the bench model for the master and as a board-level sensor emulator.

## Interface
- `ADDR`, 7'h4B, 7-bit target address matched after START.
- `SYNC_STAGES`, 2, synchronizer depth on SCL/SDA inputs (≥2).
- `clk`  in  1  system clock, ≥10× SCL rate.
- `reset`  in  1  synchronous, active-high.
- `scl_in`  in  1  bus SCL level (target never stretches the clock).
- `sda_in`  in  1  bus SDA level.
- `sda_pull`  out  1  1 = pull SDA low (open-drain). The top level drives SDA to 1'b0 when set, else Z.
- `temp_data`  in  16  sample returned on reads. It is captured at the address-ACK of a read.
- `ptr`  out  8  last pointer byte written by the master.
- `ptr_valid`  out  1  one-cycle pulse when `ptr` updates.
- `rd_done`  out  1  one-cycle pulse after the second data byte's ACK/NACK bit is sampled.
- `busy`  out  1  high from a detected START until STOP or return to IDLE.

## Operation
- Reset values: `sda_pull`=0, `ptr`=8'h00, `ptr_valid`=0, `rd_done`=0, `busy`=0, state IDLE, bit counter 0.
- SCL and SDA each pass through `SYNC_STAGES` flops and one history flop. Edges are derived from the synchronized signals only.
- START: SDA falls while SCL is high.
  - Valid in any state, which makes repeated START legal.
  - Go to ADDR, bit count 0, `busy`=1, release SDA.
- STOP: SDA rises while SCL is high.
  - Valid in any state.
  - Go to IDLE, `busy`=0, release SDA.
- Bits are sampled on SCL rising. SDA outputs change only on SCL falling.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift in 8 bits, MSB first (7 address bits + R/W).
    - On the 8th rise, if the address equals `ADDR`, go to ADDR_ACK.
    - Otherwise go to IDLE and never pull SDA.
  - ADDR_ACK: on the SCL fall following the 8th bit, assert `sda_pull`. On the next SCL fall, release it.
    - If R/W=0: go to WR_BYTE.
    - If R/W=1: latch `temp_data`, load byte index 0, go to RD_BYTE. The first data bit is driven on that same fall.
  - WR_BYTE: shift in 8 bits, then ACK as in ADDR_ACK.
    - The ACK fall updates `ptr` and pulses `ptr_valid`.
    - Bytes after the first are also ACKed and overwrite `ptr`.
  - RD_BYTE: on each SCL fall drive the next bit. `sda_pull` = ~bit, so the target pulls low for 0 and releases for 1.
    - Byte 0 is `temp[15:8]`, byte 1 is `temp[7:0]`.
    - After the 8th bit's fall, release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on SCL rise.
    - ACK (0) after byte 0: go to RD_BYTE with byte 1.
    - After byte 1, pulse `rd_done`.
      - ACK: wrap to byte 0 with the same latched sample.
      - NACK (1): go to IDLE with SDA released.
- Reset mid-transfer: next cycle is IDLE with SDA released. The remainder of the transaction is ignored until a new START.
- Simultaneous START/STOP detection with a data edge in the same cycle: START/STOP wins. The data edge is discarded.

## Timing
- Input-to-detect latency: `SYNC_STAGES`+1 clk cycles after a bus transition.
- `sda_pull` changes 1 clk after the SCL-falling detection. It must be stable before the next SCL rise, which the clock-ratio requirement guarantees.
- The 16-bit sample is captured exactly once per read address phase. Changes to `temp_data` after capture do not affect the transfer.
- `ptr_valid` and `rd_done` are high for exactly one `clk` cycle.
- No glitch: `sda_pull` never changes while synchronized SCL is high, except when released on STOP or reset.

## Structure
- Package `i2c_pkg` holds:
  - the state enum {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK};
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_RD=1'b1;
  - default address 7'h4B.
- One sub-module, `i2c_line_sync`: parameterized synchronizer plus rise/fall detector. It is instantiated twice (SCL, SDA).

## Test plan
- Read: START, 8'h97 (0x4B+R), master ACK after byte 0, NACK after byte 1, STOP, with `temp_data`=16'h1A2C.
  - Target ACKs the address.
  - Bus shows 8'h1A then 8'h2C.
  - `rd_done` pulses once.
  - `busy` falls after STOP.
- Write pointer: START, 8'h96, 8'h03, STOP.
  - Two ACKs.
  - `ptr`=8'h03 with one `ptr_valid` pulse.
- Wrong address: START, 8'h91.
  - `sda_pull` stays 0 for the whole frame.
  - State returns to IDLE.
  - `ptr` is unchanged.
- Repeated START: write 8'h96, 8'h00, then repeated START and 8'h97 read of 2 bytes (`temp_data`=16'hFF00).
  - Data bytes are FF, 00.
  - `ptr`=8'h00.
- `temp_data` changes from 16'h1234 to 16'hABCD mid-read.
  - Bytes returned are 12, 34.
- `reset` asserted during byte 0 of a read.
  - `sda_pull`=0 next cycle.
  - Following clean read of 16'h0F0F succeeds.
